// File: rtl/life_keypad_pkg.sv
// Shared key codes, button indices and sizes for the Life board keypad front end.
package life_keypad_pkg;

    localparam int unsigned KEY_W   = 3;
    localparam int unsigned NUM_BTN = 5;
    localparam int unsigned NUM_REP = 4;

    // Button bit positions within the five-wide button vectors.
    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_RIGHT = 3;
    localparam int unsigned BTN_FLIP  = 4;

    typedef enum logic [KEY_W-1:0] {
        KEY_NONE  = 3'd0,
        KEY_UP    = 3'd1,
        KEY_DOWN  = 3'd2,
        KEY_LEFT  = 3'd3,
        KEY_RIGHT = 3'd4,
        KEY_FLIP  = 3'd5
    } key_code_e;

    typedef struct packed {
        logic flip;
        logic right;
        logic left;
        logic down;
        logic up;
    } btn_vec_t;

endpackage

// File: rtl/life_debounce.sv
// One push-button: 2-FF synchroniser, saturating debounce counter and a
// registered one-cycle pulse on each accepted press.
module life_debounce #(
    parameter int unsigned CNT_W           = 24,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic stable,
    output logic press
);

    localparam longint unsigned CNT_LIMIT = (64'd1 << CNT_W) - 64'd1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    if ((DEBOUNCE_CYCLES < 2) || (longint'(DEBOUNCE_CYCLES) > CNT_LIMIT)) begin : g_cfg_err
        $error("life_debounce: DEBOUNCE_CYCLES out of range for CNT_W");
    end

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Level is only accepted after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
            press  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= ~stable;
                press  <= ~stable;
                cnt    <= '0;
            end else if (cnt != CNT_SAT) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/life_keypad.sv
// Life board keypad: debounces five buttons, auto-repeats the four cursor keys
// and serialises accepted events into a prioritised one-cycle key-code stream.
module life_keypad
    import life_keypad_pkg::*;
#(
    parameter int unsigned CNT_W           = 24,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_DELAY    = 12500000,
    parameter int unsigned REPEAT_RATE     = 2500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_flip,
    output logic [KEY_W-1:0] keys
);

    localparam longint unsigned CNT_LIMIT = (64'd1 << CNT_W) - 64'd1;
    localparam logic [CNT_W-1:0] CNT_SAT    = '1;
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    if ((REPEAT_DELAY < 1) || (longint'(REPEAT_DELAY) > CNT_LIMIT)) begin : g_delay_err
        $error("life_keypad: REPEAT_DELAY out of range for CNT_W");
    end
    if ((REPEAT_RATE < 1) || (longint'(REPEAT_RATE) > CNT_LIMIT)) begin : g_rate_err
        $error("life_keypad: REPEAT_RATE out of range for CNT_W");
    end

    btn_vec_t             btn_raw;
    logic [NUM_BTN-1:0]   press;
    logic [NUM_REP-1:0]   stable;
    logic                 flip_stable_unused;
    logic [NUM_REP-1:0]   rep_first;
    logic [NUM_REP-1:0]   rep_fire_c;
    logic [CNT_W-1:0]     rep_cnt [NUM_REP];
    logic [NUM_BTN-1:0]   pending;
    logic [NUM_BTN-1:0]   events_c;
    logic [NUM_BTN-1:0]   win_mask_c;
    logic [KEY_W-1:0]     win_code_c;

    assign btn_raw = '{flip: btn_flip, right: btn_right, left: btn_left,
                       down: btn_down, up: btn_up};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
        if (i < NUM_REP) begin : g_dir
            life_debounce #(
                .CNT_W           (CNT_W),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_db (
                .clk    (clk),
                .reset  (reset),
                .btn    (btn_raw[i]),
                .stable (stable[i]),
                .press  (press[i])
            );
        end else begin : g_flip
            life_debounce #(
                .CNT_W           (CNT_W),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_db (
                .clk    (clk),
                .reset  (reset),
                .btn    (btn_raw[i]),
                .stable (flip_stable_unused),
                .press  (press[i])
            );
        end
    end

    // Repeat fires once the held key has waited the initial delay, then each rate period.
    always_comb begin
        rep_fire_c = '0;
        for (int i = 0; i < NUM_REP; i++) begin
            rep_fire_c[i] = stable[i] && !press[i] &&
                            (rep_cnt[i] == (rep_first[i] ? DELAY_LAST : RATE_LAST));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rep_first <= '1;
            for (int i = 0; i < NUM_REP; i++) begin
                rep_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REP; i++) begin
                if (!stable[i] || press[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_first[i] <= 1'b1;
                end else if (rep_fire_c[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_first[i] <= 1'b0;
                end else if (rep_cnt[i] != CNT_SAT) begin
                    rep_cnt[i] <= rep_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign events_c = press | {1'b0, rep_fire_c};

    // Fixed priority: flip, up, down, left, right.
    always_comb begin
        win_code_c = KEY_NONE;
        win_mask_c = '0;
        if (pending[BTN_FLIP]) begin
            win_code_c           = KEY_FLIP;
            win_mask_c[BTN_FLIP] = 1'b1;
        end else if (pending[BTN_UP]) begin
            win_code_c         = KEY_UP;
            win_mask_c[BTN_UP] = 1'b1;
        end else if (pending[BTN_DOWN]) begin
            win_code_c           = KEY_DOWN;
            win_mask_c[BTN_DOWN] = 1'b1;
        end else if (pending[BTN_LEFT]) begin
            win_code_c           = KEY_LEFT;
            win_mask_c[BTN_LEFT] = 1'b1;
        end else if (pending[BTN_RIGHT]) begin
            win_code_c            = KEY_RIGHT;
            win_mask_c[BTN_RIGHT] = 1'b1;
        end
    end

    // A fresh event on the winning key in the same cycle re-arms its flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            keys    <= KEY_NONE;
        end else begin
            pending <= (pending & ~win_mask_c) | events_c;
            keys    <= win_code_c;
        end
    end

endmodule

// File: tb/tb_life_keypad.sv
// Self-checking bench for life_keypad: directed scenarios plus random button
// activity, compared every cycle against a timestamp-based behavioural model.
module tb_life_keypad;
    import life_keypad_pkg::*;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned DEB   = 4;
    localparam int unsigned RDLY  = 20;
    localparam int unsigned RRATE = 8;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       btn_up    = 1'b0;
    logic       btn_down  = 1'b0;
    logic       btn_left  = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_flip  = 1'b0;
    logic [2:0] keys;

    int checks = 0;
    int errors = 0;
    int code_cnt [8];

    always #5 clk = ~clk;

    life_keypad #(
        .CNT_W           (CNT_W),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RDLY),
        .REPEAT_RATE     (RRATE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_flip  (btn_flip),
        .keys      (keys)
    );

    // Reference model: window of synchronised samples, press timestamps, pending set.
    logic [4:0]     m_stable, m_rose, m_d1, m_d2, m_pend;
    logic [DEB-1:0] m_win [5];
    logic [3:0]     m_act;
    int unsigned    m_next [4];
    int unsigned    now_e  = 0;
    logic [2:0]     m_keys = KEY_NONE;
    int             ord [5] = '{4, 0, 1, 2, 3};

    function automatic logic [2:0] code_of(input int b);
        case (b)
            0:       return KEY_UP;
            1:       return KEY_DOWN;
            2:       return KEY_LEFT;
            3:       return KEY_RIGHT;
            default: return KEY_FLIP;
        endcase
    endfunction

    always @(posedge clk) begin : model_p
        logic [4:0] raw, ev, win;
        logic [2:0] k;
        raw = {btn_flip, btn_right, btn_left, btn_down, btn_up};
        now_e++;
        if (reset) begin
            m_stable = '0; m_rose = '0; m_d1 = '0; m_d2 = '0; m_pend = '0; m_act = '0;
            for (int b = 0; b < 5; b++) m_win[b] = '0;
            m_keys = KEY_NONE;
        end else begin
            ev = '0;
            for (int b = 0; b < 5; b++) begin
                if (m_rose[b]) begin
                    ev[b] = 1'b1;
                    if (b < 4) begin
                        m_act[b]  = 1'b1;
                        m_next[b] = now_e + RDLY;
                    end
                end else if (b < 4 && m_act[b] && m_stable[b] && now_e == m_next[b]) begin
                    ev[b]     = 1'b1;
                    m_next[b] = m_next[b] + RRATE;
                end
                if (b < 4 && !m_stable[b]) m_act[b] = 1'b0;
                m_win[b]  = {m_win[b][DEB-2:0], m_d2[b]};
                m_rose[b] = 1'b0;
                if (m_win[b] == {DEB{~m_stable[b]}}) begin
                    m_stable[b] = ~m_stable[b];
                    m_rose[b]   = m_stable[b];
                end
            end
            m_d2 = m_d1;
            m_d1 = raw;
            k   = KEY_NONE;
            win = '0;
            for (int j = 0; j < 5; j++) begin
                if (k == KEY_NONE && m_pend[ord[j]]) begin
                    k = code_of(ord[j]);
                    win[ord[j]] = 1'b1;
                end
            end
            m_pend = (m_pend & ~win) | ev;
            m_keys = k;
        end
    end

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 8; i++) code_cnt[i] = 0;
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!$isunknown(keys)) code_cnt[keys]++;
            chk(tag, keys, m_keys);
        end
    endtask

    initial begin
        clear_counts();
        repeat (3) @(negedge clk);
        chk("reset_keys", keys, KEY_NONE);
        reset = 1'b0;
        run(5, "idle");

        // Single uncontested press: one code, 7 edges after first sampling edge.
        btn_up = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t1_model", keys, m_keys);
            chk("t1_latency", keys, (i == 7) ? KEY_UP : KEY_NONE);
        end
        btn_up = 1'b0;
        run(20, "t1_release");

        // Short glitches never reach the output.
        clear_counts();
        for (int r = 0; r < 3; r++) begin
            btn_left = 1'b1;
            run(3, "t2_glitch");
            btn_left = 1'b0;
            run(1, "t2_gap");
        end
        run(20, "t2_tail");
        chk_int("t2_left_count", code_cnt[int'(KEY_LEFT)], 0);

        // Held cursor key auto-repeats; no pulse after release.
        clear_counts();
        btn_right = 1'b1;
        run(58, "t3_hold");
        btn_right = 1'b0;
        run(30, "t3_release");
        chk_int("t3_right_count", code_cnt[int'(KEY_RIGHT)], 6);

        // Flip never repeats.
        clear_counts();
        btn_flip = 1'b1;
        run(100, "t4_hold");
        btn_flip = 1'b0;
        run(20, "t4_release");
        chk_int("t4_flip_count", code_cnt[int'(KEY_FLIP)], 1);

        // Simultaneous presses serialised by priority.
        btn_up = 1'b1; btn_down = 1'b1; btn_flip = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("t5_model", keys, m_keys);
            chk("t5_order", keys, (i == 7) ? KEY_FLIP : (i == 8) ? KEY_UP :
                                  (i == 9) ? KEY_DOWN : KEY_NONE);
        end
        btn_up = 1'b0; btn_down = 1'b0; btn_flip = 1'b0;
        run(30, "t5_release");

        // Reset between acceptance and output drops the event; held key re-presses.
        btn_down = 1'b1;
        run(7, "t6_pre");
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_in_reset", keys, KEY_NONE);
        end
        reset = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            chk("t6_model", keys, m_keys);
            chk("t6_after_reset", keys, (i == 7) ? KEY_DOWN : KEY_NONE);
        end
        btn_down = 1'b0;
        run(20, "t6_release");

        // Random button activity with occasional resets.
        for (int s = 0; s < 40; s++) begin
            if ($urandom_range(0, 9) == 0) begin
                reset = 1'b1;
                run(2, "rand_reset");
                reset = 1'b0;
            end
            {btn_flip, btn_right, btn_left, btn_down, btn_up} = 5'($urandom);
            run(int'($urandom_range(1, 40)), "rand");
        end
        {btn_flip, btn_right, btn_left, btn_down, btn_up} = 5'b0;
        run(40, "rand_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
